line_controller_n: RTL and testbench

Parametrised line-follower steering controller. It samples an odd-width reflective sensor array once per servo PWM period, classifies where the line sits, and drives the left and right motor PWM channels through their reset and direction pins. It also owns the shared period counter reset. Beyond the three-sensor five-state steering it adds an enable mode, hold-on-loss and a timed search spin toward the last known line side.

---
 rtl/line_follower_pkg.sv | 28 ++
 rtl/line_classifier.sv | 40 ++++
 rtl/line_controller_n.sv | 134 +++++++++++++
 tb/tb_line_controller_n.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/line_follower_pkg.sv
// Shared types for the line-follower steering controller: FSM states, line
// classes and motor direction polarity.
package line_follower_pkg;

  typedef enum logic [2:0] {
    ST_OFF, ST_FWD, ST_GENTLE_L, ST_SHARP_L,
    ST_GENTLE_R, ST_SHARP_R, ST_SEARCH_L, ST_SEARCH_R
  } controller_state_e;

  typedef enum logic [2:0] {
    CLS_FWD, CLS_GENTLE_L, CLS_SHARP_L, CLS_GENTLE_R, CLS_SHARP_R, CLS_LOSS
  } line_class_e;

  localparam logic DIR_L_FWD = 1'b1;
  localparam logic DIR_R_FWD = 1'b0;

  // LOSS has no steering state of its own; callers resolve it before use.
  function automatic controller_state_e cls2state(input line_class_e c);
    case (c)
      CLS_GENTLE_L: return ST_GENTLE_L;
      CLS_SHARP_L:  return ST_SHARP_L;
      CLS_GENTLE_R: return ST_GENTLE_R;
      CLS_SHARP_R:  return ST_SHARP_R;
      default:      return ST_FWD;
    endcase
  endfunction

endpackage

// File: rtl/line_classifier.sv
// Combinational line position classifier: compares the number of on-line
// sensors left and right of centre and checks the centre sensor.
module line_classifier
  import line_follower_pkg::*;
#(
  parameter int NUM_SENSORS = 3
) (
  input  logic [NUM_SENSORS-1:0] s,
  output line_class_e            line_class
);

  localparam int C  = (NUM_SENSORS - 1) / 2;
  localparam int CW = $clog2(C + 1);

  logic [NUM_SENSORS-1:0] line;
  logic [CW-1:0]          l_cnt, r_cnt;

  always_comb begin
    line  = ~s;
    l_cnt = '0;
    r_cnt = '0;
    for (int i = 0; i < C; i++) begin
      l_cnt = l_cnt + CW'(line[C+1+i]);
      r_cnt = r_cnt + CW'(line[i]);
    end
  end

  always_comb begin
    line_class = CLS_FWD;
    if (&line)
      line_class = CLS_FWD;
    else if (~|line)
      line_class = CLS_LOSS;
    else if (l_cnt > r_cnt)
      line_class = line[C] ? CLS_GENTLE_L : CLS_SHARP_L;
    else if (r_cnt > l_cnt)
      line_class = line[C] ? CLS_GENTLE_R : CLS_SHARP_R;
  end

endmodule

// File: rtl/line_controller_n.sv
// Line-follower steering FSM: one decision per PWM period, hold-on-loss for a
// few periods, then a search spin toward the side the line was last seen.
module line_controller_n
  import line_follower_pkg::*;
#(
  parameter int NUM_SENSORS  = 3,
  parameter int PERIOD       = 2_000_000,
  parameter int CNT_W        = 21,
  parameter int LOST_PERIODS = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_SENSORS-1:0] sensors,
  input  logic [CNT_W-1:0]       count_in,
  output logic                   count_reset,
  output logic                   motor_l_reset,
  output logic                   motor_r_reset,
  output logic                   motor_l_direction,
  output logic                   motor_r_direction,
  output logic                   lost
);

  localparam int              LW       = $clog2(LOST_PERIODS + 1);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

  logic [NUM_SENSORS-1:0] sync_q, s;
  controller_state_e      state, state_nxt;
  logic [LW-1:0]          lost_cnt, lost_cnt_nxt;
  logic [LW:0]            lost_inc;
  logic                   lost_hit;
  logic                   last_turn, last_turn_nxt;
  logic                   tick;
  line_class_e            line_class;

  line_classifier #(.NUM_SENSORS(NUM_SENSORS)) u_cls (
    .s          (s),
    .line_class (line_class)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      s         <= '0;
      state     <= ST_OFF;
      lost_cnt  <= '0;
      last_turn <= 1'b0;
    end else begin
      sync_q    <= sensors;
      s         <= sync_q;
      state     <= state_nxt;
      lost_cnt  <= lost_cnt_nxt;
      last_turn <= last_turn_nxt;
    end
  end

  assign tick        = (count_in >= PERIOD_C) && (state != ST_OFF);
  assign count_reset = (state == ST_OFF) || tick;
  assign lost_inc    = {1'b0, lost_cnt} + (LW+1)'(1);
  assign lost_hit    = lost_inc >= (LW+1)'(LOST_PERIODS);

  always_comb begin
    state_nxt     = state;
    lost_cnt_nxt  = lost_cnt;
    last_turn_nxt = last_turn;
    if (!enable) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: state_nxt = cls2state(line_class);
        ST_FWD, ST_GENTLE_L, ST_SHARP_L, ST_GENTLE_R, ST_SHARP_R,
        ST_SEARCH_L, ST_SEARCH_R: begin
          if (tick) begin
            if (line_class != CLS_LOSS) begin
              state_nxt    = cls2state(line_class);
              lost_cnt_nxt = '0;
            end else begin
              lost_cnt_nxt = lost_hit ? LW'(LOST_PERIODS) : lost_inc[LW-1:0];
              // Search states simply keep spinning while the line stays lost.
              if (lost_hit && state != ST_SEARCH_L && state != ST_SEARCH_R)
                state_nxt = last_turn ? ST_SEARCH_R : ST_SEARCH_L;
            end
          end
        end
        default: state_nxt = ST_OFF;
      endcase
    end
    case (state_nxt)
      ST_GENTLE_L, ST_SHARP_L: last_turn_nxt = 1'b0;
      ST_GENTLE_R, ST_SHARP_R: last_turn_nxt = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    motor_l_reset     = 1'b1;
    motor_r_reset     = 1'b1;
    motor_l_direction = 1'b0;
    motor_r_direction = 1'b0;
    lost              = 1'b0;
    case (state)
      ST_FWD: begin
        motor_l_reset     = 1'b0;
        motor_r_reset     = 1'b0;
        motor_l_direction = DIR_L_FWD;
        motor_r_direction = DIR_R_FWD;
      end
      ST_GENTLE_L: begin
        motor_r_reset     = 1'b0;
        motor_r_direction = DIR_R_FWD;
      end
      ST_SHARP_L, ST_SEARCH_L: begin
        motor_l_reset     = 1'b0;
        motor_r_reset     = 1'b0;
        motor_l_direction = ~DIR_L_FWD;
        motor_r_direction = DIR_R_FWD;
        lost              = (state == ST_SEARCH_L);
      end
      ST_GENTLE_R: begin
        motor_l_reset     = 1'b0;
        motor_l_direction = DIR_L_FWD;
      end
      ST_SHARP_R, ST_SEARCH_R: begin
        motor_l_reset     = 1'b0;
        motor_r_reset     = 1'b0;
        motor_l_direction = DIR_L_FWD;
        motor_r_direction = ~DIR_R_FWD;
        lost              = (state == ST_SEARCH_R);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_line_controller_n.sv
// Directed bench for line_controller_n: a 3-sensor and a 5-sensor instance
// run side by side, each with its own period counter that clears on count_reset.
module tb_line_controller_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset  = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] sens3  = 3'b101;
  logic [4:0] sens5  = 5'b00000;
  logic [3:0] cnt3   = '0;
  logic [3:0] cnt5   = '0;
  logic cr3, lr3, rr3, ld3, rd3, lost3;
  logic cr5, lr5, rr5, ld5, rd5, lost5;

  // {l_reset, r_reset, l_dir, r_dir, lost}
  wire [4:0] out3 = {lr3, rr3, ld3, rd3, lost3};
  wire [4:0] out5 = {lr5, rr5, ld5, rd5, lost5};

  always @(posedge clk) begin
    cnt3 <= cr3 ? 4'd0 : cnt3 + 4'd1;
    cnt5 <= cr5 ? 4'd0 : cnt5 + 4'd1;
  end

  line_controller_n #(.NUM_SENSORS(3), .PERIOD(9), .CNT_W(4), .LOST_PERIODS(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .sensors(sens3), .count_in(cnt3),
    .count_reset(cr3), .motor_l_reset(lr3), .motor_r_reset(rr3),
    .motor_l_direction(ld3), .motor_r_direction(rd3), .lost(lost3)
  );

  line_controller_n #(.NUM_SENSORS(5), .PERIOD(9), .CNT_W(4), .LOST_PERIODS(3)) dut5 (
    .clk(clk), .reset(reset), .enable(enable), .sensors(sens5), .count_in(cnt5),
    .count_reset(cr5), .motor_l_reset(lr5), .motor_r_reset(rr5),
    .motor_l_direction(ld5), .motor_r_direction(rd5), .lost(lost5)
  );

  localparam logic [4:0] O_OFF = 5'b11000, O_FWD = 5'b00100, O_GL = 5'b10000,
                         O_SL  = 5'b00000, O_GR  = 5'b01100, O_SR = 5'b00110,
                         O_SCL = 5'b00001, O_SCR = 5'b00111;

  typedef struct {
    bit         sel;
    logic [4:0] sens;
    logic [4:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[14];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic wait_tick(input bit sel, input string name);
    int k = 0;
    while (((sel ? cr5 : cr3) !== 1'b1) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no tick within 40 cycles", name);
    end
  endtask

  task automatic next_tick_check(input bit sel, input logic [4:0] exp, input string name);
    wait_tick(sel, name);
    @(negedge clk);
    check(name, sel ? out5 : out3, exp);
  endtask

  task automatic wait_cnt3(input logic [3:0] v, input string name);
    int k = 0;
    while (cnt3 !== v && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: counter never reached %0d", name, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0]  = '{1'b0, 5'b00011, O_SL, "t3_sharp_l"};
    tbl[1]  = '{1'b0, 5'b00010, O_FWD, "t3_balanced_fwd"};
    tbl[2]  = '{1'b0, 5'b00001, O_GL, "t3_gentle_l"};
    tbl[3]  = '{1'b0, 5'b00110, O_SR, "t3_sharp_r"};
    tbl[4]  = '{1'b0, 5'b00000, O_FWD, "t3_all_black"};
    tbl[5]  = '{1'b0, 5'b00100, O_GR, "t3_gentle_r"};
    tbl[6]  = '{1'b0, 5'b00101, O_FWD, "t3_centre_fwd"};
    tbl[7]  = '{1'b1, 5'b00111, O_SL, "t5_sharp_l_l2"};
    tbl[8]  = '{1'b1, 5'b11000, O_GR, "t5_gentle_r_r2c"};
    tbl[9]  = '{1'b1, 5'b11100, O_SR, "t5_sharp_r_r2"};
    tbl[10] = '{1'b1, 5'b00000, O_FWD, "t5_all_black"};
    tbl[11] = '{1'b1, 5'b00011, O_GL, "t5_gentle_l_l2c"};
    tbl[12] = '{1'b1, 5'b11011, O_FWD, "t5_centre_only"};
    tbl[13] = '{1'b1, 5'b01111, O_SL, "t5_sharp_l_l1"};

    // reset and enable
    repeat (4) @(negedge clk);
    check("reset_outs", out3, O_OFF);
    check("reset_count_reset", {4'b0, cr3}, 5'b00001);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    check("enable_fwd3", out3, O_FWD);
    check("enable_fwd5", out5, O_FWD);

    // period length
    wait_tick(1'b0, "period_first");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cr3 !== 1'b1 && n < 40);
    check("period_len", 5'(n), 5'd10);
    @(negedge clk);

    // sensor-to-state latency
    repeat (4) @(negedge clk);
    sens3 = 3'b011;
    wait_tick(1'b0, "mid_period");
    check("pre_tick_still_fwd", out3, O_FWD);
    @(negedge clk);
    check("post_tick_sharp_l", out3, O_SL);
    wait_cnt3(4'd8, "late_align");
    sens3 = 3'b001;
    next_tick_check(1'b0, O_SL, "late_change_missed");
    next_tick_check(1'b0, O_GL, "late_change_seen");

    foreach (tbl[i]) begin
      if (tbl[i].sel) sens5 = tbl[i].sens;
      else            sens3 = tbl[i].sens[2:0];
      next_tick_check(tbl[i].sel, tbl[i].exp, tbl[i].name);
    end

    // hold on loss, then search toward the right
    sens3 = 3'b100;
    next_tick_check(1'b0, O_GR, "loss_setup_gr");
    sens3 = 3'b111;
    next_tick_check(1'b0, O_GR, "loss_hold1");
    next_tick_check(1'b0, O_GR, "loss_hold2");
    next_tick_check(1'b0, O_SCR, "search_r");
    sens3 = 3'b101;
    next_tick_check(1'b0, O_FWD, "search_recover_fwd");

    // search toward the left on the 5-sensor unit (last turn was left)
    sens5 = 5'b11111;
    next_tick_check(1'b1, O_SL, "t5_loss_hold1");
    next_tick_check(1'b1, O_SL, "t5_loss_hold2");
    next_tick_check(1'b1, O_SCL, "t5_search_l");

    // enable drop on a tick: OFF wins, lost_cnt survives
    sens3 = 3'b110;
    next_tick_check(1'b0, O_SR, "drop_setup_sr");
    sens3 = 3'b111;
    next_tick_check(1'b0, O_SR, "drop_loss_hold");
    wait_cnt3(4'd9, "drop_align");
    check("drop_tick_count_reset", {4'b0, cr3}, 5'b00001);
    enable = 1'b0;
    @(negedge clk);
    check("drop_off", out3, O_OFF);
    repeat (2) @(negedge clk);
    check("off_count_reset_held", {4'b0, cr3}, 5'b00001);
    enable = 1'b1;
    @(negedge clk);
    check("reenable_loss_as_fwd", out3, O_FWD);
    next_tick_check(1'b0, O_FWD, "lost_cnt_kept_hold");
    next_tick_check(1'b0, O_SCR, "lost_cnt_kept_search");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
